arith_check_rr: RTL and testbench

Parametrised round-robin arithmetic checker; next generation of the testbench monitor. DUT samples are spread across NUM_LANES checker lanes in one-hot rotation. Each lane recomputes the expected result of the configured operation over a multi-cycle path and XORs it with the DUT result. An in-order collector emits one per-sample diff with a valid strobe and keeps saturating sample and error counters. Sits between the DUT harness and the result/logging logic.

---
 rtl/arith_check_pkg.sv | 23 ++
 rtl/arith_check_lane.sv | 73 +++++++
 rtl/arith_check_rr.sv | 220 ++++++++++++++++++++++
 tb/tb_arith_check_rr.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/arith_check_pkg.sv
// Shared definitions for the round-robin arithmetic checker.
// Holds the operation encoding and the expected-result function. The function
// works on 64-bit values; callers pass zero-extended operands and keep the low
// WIDTH bits of the result. Add, subtract and multiply all give correct low
// bits under that truncation. WIDTH must not exceed 64.
package arith_check_pkg;

    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_MUL = 2;

    function automatic logic [63:0] arith_expected(input int op,
                                                   input logic [63:0] a,
                                                   input logic [63:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return a * b;
            default: return a + b;
        endcase
    endfunction

endpackage

// File: rtl/arith_check_lane.sv
// One checker lane: latches a sample, recomputes the expected result over a
// LANE_LAT-cycle multicycle path and registers expected ^ DUT result.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   i_load             capture i_a/i_b/i_os this edge
//   i_a, i_b, i_os     DUT operands and DUT result
//   o_diff             registered expected ^ os, updated LANE_LAT edges after load
module arith_check_lane
    import arith_check_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int LANE_LAT = 2,
    parameter int OP       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_os,
    output logic [WIDTH-1:0] o_diff
);

    localparam int CW = $clog2(LANE_LAT + 1);

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, os_q, os_d, diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] expected;

    // Operands stay stable for LANE_LAT cycles, so this path may be
    // constrained as multicycle.
    assign expected = WIDTH'(arith_expected(OP, 64'(a_q), 64'(b_q)));

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        os_d   = os_q;
        cnt_d  = cnt_q;
        diff_d = diff_q;
        // Finishing the old sample and loading a new one may share an edge
        // when the lane is reused at exactly LANE_LAT spacing.
        if (cnt_q == CW'(1)) begin
            diff_d = expected ^ os_q;
        end
        if (i_load) begin
            a_d   = i_a;
            b_d   = i_b;
            os_d  = i_os;
            cnt_d = CW'(LANE_LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            os_q   <= '0;
            cnt_q  <= '0;
            diff_q <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            os_q   <= os_d;
            cnt_q  <= cnt_d;
            diff_q <= diff_d;
        end
    end

    assign o_diff = diff_q;

endmodule

// File: rtl/arith_check_rr.sv
// Round-robin arithmetic checker. Accepted samples go to NUM_LANES lanes in
// one-hot rotation; an in-order collector returns one diff per sample,
// LANE_LAT+1 edges after acceptance, and keeps saturating counters.
// Optional feature macro: ARITH_CHECK_FIRST_FAIL_EN (capture of the first
// failing sample into o_first_*; tied to 0 when undefined).
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   i_valid, i_dut_ia/ib/os         sample strobe, DUT operands and result
//   o_mon_ready                     high once the checker accepts samples
//   o_diff_valid, o_diff            per-sample strobe and expected ^ DUT
//   o_sample_cnt, o_err_cnt         saturating checked / failing counts
//   o_err_sticky                    set on first mismatch
//   o_first_a/b/os, o_first_idx     first failing sample and its index
module arith_check_rr
    import arith_check_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int NUM_LANES = 4,
    parameter int LANE_LAT  = 2,
    parameter int OP        = 0,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_valid,
    input  logic [WIDTH-1:0]     i_dut_ia,
    input  logic [WIDTH-1:0]     i_dut_ib,
    input  logic [WIDTH-1:0]     i_dut_os,
    output logic                 o_mon_ready,
    output logic                 o_diff_valid,
    output logic [WIDTH-1:0]     o_diff,
    output logic [CNT_WIDTH-1:0] o_sample_cnt,
    output logic [CNT_WIDTH-1:0] o_err_cnt,
    output logic                 o_err_sticky,
    output logic [WIDTH-1:0]     o_first_a,
    output logic [WIDTH-1:0]     o_first_b,
    output logic [WIDTH-1:0]     o_first_os,
    output logic [CNT_WIDTH-1:0] o_first_idx
);

    localparam int IDX_W = $clog2(NUM_LANES);
    localparam int RDY_W = $clog2(LANE_LAT + 3);
    localparam int DEPTH = LANE_LAT + 1;

    logic [RDY_W-1:0]     rdy_cnt_q, rdy_cnt_d;
    logic                 ready, accept, fail_now;
    logic [NUM_LANES-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0]     ptr_idx;
    logic [WIDTH-1:0]     lane_diff [NUM_LANES];
    logic [DEPTH-1:0]     col_vld_q, col_vld_d;
    logic [IDX_W-1:0]     col_idx_q [DEPTH];
    logic [IDX_W-1:0]     col_idx_d [DEPTH];
    logic                 diff_valid_q, diff_valid_d;
    logic [WIDTH-1:0]     diff_q, diff_d;
    logic [CNT_WIDTH-1:0] sample_cnt_q, sample_cnt_d, err_cnt_q, err_cnt_d;
    logic                 sticky_q, sticky_d;

    // Ready waits until any pre-reset lane activity has fully drained.
    assign ready    = (rdy_cnt_q == RDY_W'(LANE_LAT + 2));
    assign accept   = i_valid && ready;
    assign fail_now = diff_valid_q && (|diff_q);

    always_comb begin
        rdy_cnt_d = ready ? rdy_cnt_q : rdy_cnt_q + RDY_W'(1);
        ptr_d     = accept ? {ptr_q[NUM_LANES-2:0], ptr_q[NUM_LANES-1]} : ptr_q;
        ptr_idx   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (ptr_q[i]) ptr_idx = IDX_W'(i);
        end
        col_vld_d    = {col_vld_q[DEPTH-2:0], accept};
        col_idx_d[0] = ptr_idx;
        for (int k = 1; k < DEPTH; k++) begin
            col_idx_d[k] = col_idx_q[k-1];
        end
        // The tail stage lines up with the lane registering its diff.
        diff_valid_d = col_vld_q[DEPTH-1];
        diff_d       = col_vld_q[DEPTH-1] ? lane_diff[col_idx_q[DEPTH-1]] : '0;
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        if (diff_valid_q && sample_cnt_q != '1) sample_cnt_d = sample_cnt_q + CNT_WIDTH'(1);
        if (fail_now && err_cnt_q != '1)        err_cnt_d    = err_cnt_q + CNT_WIDTH'(1);
        sticky_d = sticky_q | fail_now;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_cnt_q    <= '0;
            ptr_q        <= NUM_LANES'(1);
            col_vld_q    <= '0;
            for (int k = 0; k < DEPTH; k++) col_idx_q[k] <= '0;
            diff_valid_q <= 1'b0;
            diff_q       <= '0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            sticky_q     <= 1'b0;
        end else begin
            rdy_cnt_q    <= rdy_cnt_d;
            ptr_q        <= ptr_d;
            col_vld_q    <= col_vld_d;
            for (int k = 0; k < DEPTH; k++) col_idx_q[k] <= col_idx_d[k];
            diff_valid_q <= diff_valid_d;
            diff_q       <= diff_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            sticky_q     <= sticky_d;
        end
    end

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        arith_check_lane #(
            .WIDTH   (WIDTH),
            .LANE_LAT(LANE_LAT),
            .OP      (OP)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .i_load(accept && ptr_q[gi]),
            .i_a   (i_dut_ia),
            .i_b   (i_dut_ib),
            .i_os  (i_dut_os),
            .o_diff(lane_diff[gi])
        );
    end

    assign o_mon_ready  = ready;
    assign o_diff_valid = diff_valid_q;
    assign o_diff       = diff_q;
    assign o_sample_cnt = sample_cnt_q;
    assign o_err_cnt    = err_cnt_q;
    assign o_err_sticky = sticky_q;

`ifdef ARITH_CHECK_FIRST_FAIL_EN
    // Sample payload travels beside {valid, lane}; the out_* stage is aligned
    // with diff_q so the capture fires on the same edge as the sticky bit.
    logic [WIDTH-1:0]     col_a_q [DEPTH], col_a_d [DEPTH];
    logic [WIDTH-1:0]     col_b_q [DEPTH], col_b_d [DEPTH];
    logic [WIDTH-1:0]     col_os_q [DEPTH], col_os_d [DEPTH];
    logic [CNT_WIDTH-1:0] col_n_q [DEPTH], col_n_d [DEPTH];
    logic [CNT_WIDTH-1:0] acc_idx_q, acc_idx_d;
    logic [WIDTH-1:0]     out_a_q, out_a_d, out_b_q, out_b_d, out_os_q, out_os_d;
    logic [CNT_WIDTH-1:0] out_n_q, out_n_d;
    logic [WIDTH-1:0]     first_a_q, first_a_d, first_b_q, first_b_d, first_os_q, first_os_d;
    logic [CNT_WIDTH-1:0] first_n_q, first_n_d;

    always_comb begin
        acc_idx_d = (accept && acc_idx_q != '1) ? acc_idx_q + CNT_WIDTH'(1) : acc_idx_q;
        col_a_d[0]  = i_dut_ia;
        col_b_d[0]  = i_dut_ib;
        col_os_d[0] = i_dut_os;
        col_n_d[0]  = acc_idx_q;
        for (int k = 1; k < DEPTH; k++) begin
            col_a_d[k]  = col_a_q[k-1];
            col_b_d[k]  = col_b_q[k-1];
            col_os_d[k] = col_os_q[k-1];
            col_n_d[k]  = col_n_q[k-1];
        end
        out_a_d  = col_a_q[DEPTH-1];
        out_b_d  = col_b_q[DEPTH-1];
        out_os_d = col_os_q[DEPTH-1];
        out_n_d  = col_n_q[DEPTH-1];
        first_a_d  = first_a_q;
        first_b_d  = first_b_q;
        first_os_d = first_os_q;
        first_n_d  = first_n_q;
        if (fail_now && !sticky_q) begin
            first_a_d  = out_a_q;
            first_b_d  = out_b_q;
            first_os_d = out_os_q;
            first_n_d  = out_n_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                col_a_q[k]  <= '0;
                col_b_q[k]  <= '0;
                col_os_q[k] <= '0;
                col_n_q[k]  <= '0;
            end
            acc_idx_q  <= '0;
            out_a_q    <= '0;
            out_b_q    <= '0;
            out_os_q   <= '0;
            out_n_q    <= '0;
            first_a_q  <= '0;
            first_b_q  <= '0;
            first_os_q <= '0;
            first_n_q  <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                col_a_q[k]  <= col_a_d[k];
                col_b_q[k]  <= col_b_d[k];
                col_os_q[k] <= col_os_d[k];
                col_n_q[k]  <= col_n_d[k];
            end
            acc_idx_q  <= acc_idx_d;
            out_a_q    <= out_a_d;
            out_b_q    <= out_b_d;
            out_os_q   <= out_os_d;
            out_n_q    <= out_n_d;
            first_a_q  <= first_a_d;
            first_b_q  <= first_b_d;
            first_os_q <= first_os_d;
            first_n_q  <= first_n_d;
        end
    end

    assign o_first_a   = first_a_q;
    assign o_first_b   = first_b_q;
    assign o_first_os  = first_os_q;
    assign o_first_idx = first_n_q;
`else
    assign o_first_a   = '0;
    assign o_first_b   = '0;
    assign o_first_os  = '0;
    assign o_first_idx = '0;
`endif

endmodule

// File: tb/tb_arith_check_rr.sv
// Bench for arith_check_rr: two instances share one stimulus stream.
//   dut 0: add, 4 lanes, LANE_LAT 2, 16-bit counters
//   dut 1: mul, 3 lanes, LANE_LAT 3, 4-bit counters (full-rate lane reuse)
// The DUT result driven is the true result XOR a chosen mask, so the expected
// diff of each accepted sample is that mask.
module tb_arith_check_rr;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_valid = 1'b0;
    logic [31:0] ia = '0, ib = '0, os0 = '0, os1 = '0;

    logic        rdy0, dv0, st0, rdy1, dv1, st1;
    logic [31:0] diff0, fa0, fb0, fos0, diff1, fa1, fb1, fos1;
    logic [15:0] sc0, ec0, fidx0;
    logic [3:0]  sc1, ec1, fidx1;

    always #5 clk = ~clk;

    arith_check_rr #(.WIDTH(32), .NUM_LANES(4), .LANE_LAT(2), .OP(0), .CNT_WIDTH(16)) u_add (
        .clk(clk), .reset(reset), .i_valid(i_valid), .i_dut_ia(ia), .i_dut_ib(ib), .i_dut_os(os0),
        .o_mon_ready(rdy0), .o_diff_valid(dv0), .o_diff(diff0), .o_sample_cnt(sc0), .o_err_cnt(ec0),
        .o_err_sticky(st0), .o_first_a(fa0), .o_first_b(fb0), .o_first_os(fos0), .o_first_idx(fidx0));

    arith_check_rr #(.WIDTH(32), .NUM_LANES(3), .LANE_LAT(3), .OP(2), .CNT_WIDTH(4)) u_mul (
        .clk(clk), .reset(reset), .i_valid(i_valid), .i_dut_ia(ia), .i_dut_ib(ib), .i_dut_os(os1),
        .o_mon_ready(rdy1), .o_diff_valid(dv1), .o_diff(diff1), .o_sample_cnt(sc1), .o_err_cnt(ec1),
        .o_err_sticky(st1), .o_first_a(fa1), .o_first_b(fb1), .o_first_os(fos1), .o_first_idx(fidx1));

    logic        obs_rdy [2], obs_dv [2], obs_st [2];
    logic [31:0] obs_diff [2], obs_fa [2], obs_fb [2], obs_fos [2];
    logic [15:0] obs_sc [2], obs_ec [2], obs_fidx [2];
    assign obs_rdy[0] = rdy0;   assign obs_rdy[1] = rdy1;
    assign obs_dv[0] = dv0;     assign obs_dv[1] = dv1;
    assign obs_st[0] = st0;     assign obs_st[1] = st1;
    assign obs_diff[0] = diff0; assign obs_diff[1] = diff1;
    assign obs_fa[0] = fa0;     assign obs_fa[1] = fa1;
    assign obs_fb[0] = fb0;     assign obs_fb[1] = fb1;
    assign obs_fos[0] = fos0;   assign obs_fos[1] = fos1;
    assign obs_sc[0] = sc0;     assign obs_sc[1] = {12'b0, sc1};
    assign obs_ec[0] = ec0;     assign obs_ec[1] = {12'b0, ec1};
    assign obs_fidx[0] = fidx0; assign obs_fidx[1] = {12'b0, fidx1};

    int checks = 0;
    int errors = 0;

    // Scoreboard state, one slot per instance.
    typedef struct {
        logic [31:0] diff, a, b, os;
        int          idx;
        int          due;
    } exp_t;

    int          lat [2]  = '{2, 3};
    int          cmax [2] = '{65535, 15};
    exp_t        ring [128];
    int          hd [2], tl [2], rc [2], scnt [2], ecnt [2], accn [2];
    bit          sticky [2], ev [2];
    logic [31:0] ed [2], ea [2], eb [2], eos [2];
    int          eidx [2];
    logic [31:0] fa_m [2], fb_m [2], fos_m [2];
    int          fidx_m [2];
    int          cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, update the model at the edge, then
    // compare every output of both instances on the falling edge.
    task automatic step(input bit v, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] m0, input logic [31:0] m1);
        i_valid = v;
        ia      = a;
        ib      = b;
        os0     = (a + b) ^ m0;
        os1     = (a * b) ^ m1;
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            logic [31:0] m, o;
            m = (d == 0) ? m0 : m1;
            o = (d == 0) ? os0 : os1;
            if (reset) begin
                hd[d] = 0; tl[d] = 0; rc[d] = 0; scnt[d] = 0; ecnt[d] = 0; accn[d] = 0;
                sticky[d] = 0;
                fa_m[d] = '0; fb_m[d] = '0; fos_m[d] = '0; fidx_m[d] = 0;
            end else begin
                if (ev[d]) begin
                    if (scnt[d] < cmax[d]) scnt[d]++;
                    if (ed[d] != 0) begin
                        if (ecnt[d] < cmax[d]) ecnt[d]++;
                        if (!sticky[d]) begin
                            sticky[d] = 1;
`ifdef ARITH_CHECK_FIRST_FAIL_EN
                            fa_m[d] = ea[d]; fb_m[d] = eb[d]; fos_m[d] = eos[d]; fidx_m[d] = eidx[d];
`endif
                        end
                    end
                end
                if (v && rc[d] >= lat[d] + 2) begin
                    ring[d*64 + tl[d]%64] = '{diff: m, a: a, b: b, os: o, idx: accn[d], due: cyc + lat[d] + 1};
                    tl[d]++;
                    if (accn[d] < cmax[d]) accn[d]++;
                end
                if (rc[d] < lat[d] + 2) rc[d]++;
            end
            ev[d] = 0; ed[d] = '0;
            if (!reset && hd[d] != tl[d] && ring[d*64 + hd[d]%64].due == cyc) begin
                ev[d] = 1;
                ed[d] = ring[d*64 + hd[d]%64].diff;
                ea[d] = ring[d*64 + hd[d]%64].a;
                eb[d] = ring[d*64 + hd[d]%64].b;
                eos[d] = ring[d*64 + hd[d]%64].os;
                eidx[d] = ring[d*64 + hd[d]%64].idx;
                hd[d]++;
            end
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("c%0d_d%0d_ready", cyc, d), 64'(obs_rdy[d]), 64'(rc[d] >= lat[d] + 2));
            chk($sformatf("c%0d_d%0d_valid", cyc, d), 64'(obs_dv[d]), 64'(ev[d]));
            chk($sformatf("c%0d_d%0d_diff", cyc, d), 64'(obs_diff[d]), 64'(ed[d]));
            chk($sformatf("c%0d_d%0d_sample_cnt", cyc, d), 64'(obs_sc[d]), 64'(scnt[d]));
            chk($sformatf("c%0d_d%0d_err_cnt", cyc, d), 64'(obs_ec[d]), 64'(ecnt[d]));
            chk($sformatf("c%0d_d%0d_sticky", cyc, d), 64'(obs_st[d]), 64'(sticky[d]));
            chk($sformatf("c%0d_d%0d_first_a", cyc, d), 64'(obs_fa[d]), 64'(fa_m[d]));
            chk($sformatf("c%0d_d%0d_first_b", cyc, d), 64'(obs_fb[d]), 64'(fb_m[d]));
            chk($sformatf("c%0d_d%0d_first_os", cyc, d), 64'(obs_fos[d]), 64'(fos_m[d]));
            chk($sformatf("c%0d_d%0d_first_idx", cyc, d), 64'(obs_fidx[d]), 64'(fidx_m[d]));
        end
    endtask

    logic [31:0] a5, b5, ra, rb, m0, m1;

    initial begin
        for (int d = 0; d < 2; d++) begin
            hd[d] = 0; tl[d] = 0; rc[d] = 0; scnt[d] = 0; ecnt[d] = 0; accn[d] = 0;
            sticky[d] = 0; ev[d] = 0; ed[d] = '0;
            fa_m[d] = '0; fb_m[d] = '0; fos_m[d] = '0; fidx_m[d] = 0;
        end

        // Reset release with i_valid held high.
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(1, 32'h11, 32'h22, 0, 0);
        chk("reset_valid0", 64'(dv0), 64'd0);
        chk("reset_sample_cnt0", 64'(sc0), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step(1, 32'h11, 32'h22, 0, 0);
        chk("ready0_after3", 64'(rdy0), 64'd0);
        step(1, 32'h11, 32'h22, 0, 0);
        chk("ready0_after4", 64'(rdy0), 64'd1);
        chk("ready1_after4", 64'(rdy1), 64'd0);
        step(1, 32'h11, 32'h22, 0, 0);
        chk("ready1_after5", 64'(rdy1), 64'd1);
        chk("pre_ready_sample_cnt0", 64'(sc0), 64'd0);
        chk("pre_ready_valid0", 64'(dv0), 64'd0);

        // 100 back-to-back samples; mul sample 5 carries a bit-3 error.
        reset = 1'b1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);
        for (int i = 0; i < 100; i++) begin
            ra = (i == 0) ? 32'hFFFF_FFFF : 32'h9E37_79B9 * i;
            rb = (i == 0) ? 32'h1 : 32'h1234 + i;
            if (i == 5) begin a5 = ra; b5 = rb; end
            step(1, ra, rb, 0, (i == 5) ? 32'h8 : 32'h0);
        end
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0);
        chk("add_sample_cnt_100", 64'(sc0), 64'd100);
        chk("add_err_cnt_0", 64'(ec0), 64'd0);
        chk("add_sticky_0", 64'(st0), 64'd0);
        chk("mul_sample_cnt_sat", 64'(sc1), 64'd15);
        chk("mul_err_cnt_1", 64'(ec1), 64'd1);
        chk("mul_sticky_1", 64'(st1), 64'd1);
`ifdef ARITH_CHECK_FIRST_FAIL_EN
        chk("mul_first_idx", 64'(fidx1), 64'd5);
        chk("mul_first_a", 64'(fa1), 64'(a5));
        chk("mul_first_b", 64'(fb1), 64'(b5));
        chk("mul_first_os", 64'(fos1), 64'((a5 * b5) ^ 32'h8));
`else
        chk("mul_first_idx_off", 64'(fidx1), 64'd0);
        chk("mul_first_a_off", 64'(fa1), 64'd0);
`endif

        // Random gaps at about 30% duty with occasional injected errors.
        for (int i = 0; i < 80; i++) begin
            ra = $urandom;
            rb = $urandom;
            m0 = ($urandom_range(0, 3) == 0) ? ($urandom | 32'h1) : 32'h0;
            m1 = ($urandom_range(0, 3) == 0) ? ($urandom | 32'h2) : 32'h0;
            step($urandom_range(0, 9) < 3, ra, rb, m0, m1);
        end

        // 20 failing samples back-to-back: 4-bit counters must pin at 15.
        for (int i = 0; i < 20; i++) begin
            step(1, 32'h100 + i, 32'h3 * i, 32'h8000_0000 >> i, 32'h1 << i);
        end
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0);
        chk("mul_err_cnt_sat", 64'(ec1), 64'd15);
        chk("mul_sample_cnt_hold", 64'(sc1), 64'd15);
        chk("add_sticky_set", 64'(st0), 64'd1);

        // Reset with two samples in flight.
        step(1, 32'h5, 32'h6, 32'h1, 32'h1);
        step(1, 32'h7, 32'h8, 32'h1, 32'h1);
        reset = 1'b1;
        step(0, 0, 0, 0, 0);
        chk("midreset_valid0", 64'(dv0), 64'd0);
        chk("midreset_valid1", 64'(dv1), 64'd0);
        chk("midreset_sample_cnt0", 64'(sc0), 64'd0);
        chk("midreset_err_cnt1", 64'(ec1), 64'd0);
        chk("midreset_sticky0", 64'(st0), 64'd0);
        chk("midreset_ready0", 64'(rdy0), 64'd0);
        step(0, 0, 0, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 32'hA0 + i, 32'h3 + i, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0);
        chk("post_reset_sample_cnt0", 64'(sc0), 64'd5);
        chk("post_reset_sample_cnt1", 64'(sc1), 64'd5);
        chk("post_reset_err_cnt0", 64'(ec0), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
